dll_lock_ctrl: RTL

//  Sequences DLL lock acquisition around the false-lock detector (FLD) outputs.

---
 rtl/dll_pkg.sv | 26 ++
 rtl/dll_lock_qual.sv | 46 ++++
 rtl/dll_lock_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dll_pkg.sv
// rtl/dll_pkg.sv - shared state type and default timing constants for the DLL lock controller
//
// Contents:
//   dll_state_t  - controller state encoding
//   DLL_*        - default LOCK_CNT / ACQ_TIMEOUT / RECOVER_CYC / SEE_CNT_W values
//   is_tracking  - true in states where charge-pump requests are passed through
package dll_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RECOVER = 3'd1,
        ST_ACQUIRE = 3'd2,
        ST_CONFIRM = 3'd3,
        ST_LOCKED  = 3'd4
    } dll_state_t;

    localparam int DLL_LOCK_CNT    = 16;
    localparam int DLL_ACQ_TIMEOUT = 1024;
    localparam int DLL_RECOVER_CYC = 8;
    localparam int DLL_SEE_CNT_W   = 8;

    function automatic logic is_tracking(input dll_state_t s);
        return (s == ST_ACQUIRE) || (s == ST_CONFIRM) || (s == ST_LOCKED);
    endfunction

endpackage

// File: rtl/dll_lock_qual.sv
// rtl/dll_lock_qual.sv - lock qualification and lock-loss counters
//
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   acq_en      counting consecutive lock cycles (ACQUIRE/CONFIRM, no fault/timeout/disable)
//   trk_en      counting consecutive lock-low cycles (LOCKED, no fault/disable)
//   fld_lock    FLD lock indication
//   qualified   LOCK_CNT consecutive lock cycles have been seen
//   lost        this cycle is the LOCK_CNT-th consecutive lock-low cycle while locked
module dll_lock_qual
    import dll_pkg::*;
#(
    parameter int LOCK_CNT = DLL_LOCK_CNT
) (
    input  logic clk,
    input  logic rst,
    input  logic acq_en,
    input  logic trk_en,
    input  logic fld_lock,
    output logic qualified,
    output logic lost
);

    localparam int CW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(LOCK_CNT);
    localparam logic [CW-1:0] DROP_LAST = CW'(LOCK_CNT - 1);

    logic [CW-1:0] lock_cnt;
    logic [CW-1:0] drop_cnt;

    assign qualified = (lock_cnt == CNT_FULL);
    assign lost      = trk_en & ~fld_lock & (drop_cnt == DROP_LAST);

    // Both counters fall back to zero whenever their enable drops, so any
    // exit from the counting states leaves them clean for the next entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            lock_cnt <= (acq_en && !qualified && fld_lock) ? lock_cnt + 1'b1 : '0;
            drop_cnt <= (trk_en && !fld_lock && !lost) ? drop_cnt + 1'b1 : '0;
        end
    end

endmodule

// File: rtl/dll_lock_ctrl.sv
// rtl/dll_lock_ctrl.sv - DLL lock acquisition sequencer between false-lock detector and charge pump
//
// Optional feature macro: DLL_LOCK_CTRL_SEE_FILTER_EN (SEE flag must be high two
// consecutive cycles to be accepted; default accepts any single cycle).
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_i                  enable; low forces IDLE
//   fld_up_i/fld_down_i   FLD charge-pump requests
//   fld_lock_i            FLD lock indication
//   fld_see_i             FLD invalid-pattern flag
//   cp_up_o/cp_down_o     gated charge-pump requests (registered)
//   vctrl_rst_o           VCDL control-voltage reset (high in RECOVER)
//   locked_o              qualified lock
//   acq_fail_o            sticky acquisition-timeout flag
//   see_cnt_o             saturating count of accepted faults
module dll_lock_ctrl
    import dll_pkg::*;
#(
    parameter int LOCK_CNT    = DLL_LOCK_CNT,
    parameter int ACQ_TIMEOUT = DLL_ACQ_TIMEOUT,
    parameter int RECOVER_CYC = DLL_RECOVER_CYC,
    parameter int SEE_CNT_W   = DLL_SEE_CNT_W
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 fld_up_i,
    input  logic                 fld_down_i,
    input  logic                 fld_lock_i,
    input  logic                 fld_see_i,
    output logic                 cp_up_o,
    output logic                 cp_down_o,
    output logic                 vctrl_rst_o,
    output logic                 locked_o,
    output logic                 acq_fail_o,
    output logic [SEE_CNT_W-1:0] see_cnt_o
);

    localparam int TW = $clog2(ACQ_TIMEOUT + 1);
    localparam int RW = $clog2(RECOVER_CYC + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(ACQ_TIMEOUT - 1);
    localparam logic [RW-1:0] REC_LAST = RW'(RECOVER_CYC - 1);

    dll_state_t    state;
    dll_state_t    state_nxt;
    logic [TW-1:0] acq_tmr;
    logic [RW-1:0] rec_cnt;
    logic          see_acc;
    logic          fault;
    logic          in_acq;
    logic          timeout;
    logic          rec_done;
    logic          acq_en;
    logic          trk_en;
    logic          qualified;
    logic          lost;
    logic          pass_cp;

`ifdef DLL_LOCK_CTRL_SEE_FILTER_EN
    logic see_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            see_q <= 1'b0;
        end else begin
            see_q <= fld_see_i;
        end
    end

    assign see_acc = fld_see_i & see_q;
`else
    assign see_acc = fld_see_i;
`endif

    assign fault    = see_acc | (fld_up_i & fld_down_i);
    assign in_acq   = (state == ST_ACQUIRE) || (state == ST_CONFIRM);
    assign timeout  = in_acq && (acq_tmr == TMR_LAST);
    assign rec_done = (state == ST_RECOVER) && (rec_cnt == REC_LAST);
    assign acq_en   = en_i & ~fault & in_acq & ~timeout;
    assign trk_en   = en_i & ~fault & (state == ST_LOCKED);

    dll_lock_qual #(
        .LOCK_CNT (LOCK_CNT)
    ) u_qual (
        .clk       (clk_i),
        .rst       (rst_i),
        .acq_en    (acq_en),
        .trk_en    (trk_en),
        .fld_lock  (fld_lock_i),
        .qualified (qualified),
        .lost      (lost)
    );

    // Priority order: disable > fault > timeout > lock transitions.
    always_comb begin
        state_nxt = state;
        if (!en_i) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    state_nxt = ST_RECOVER;
                ST_RECOVER: if (rec_done) state_nxt = ST_ACQUIRE;
                ST_ACQUIRE, ST_CONFIRM: begin
                    if (fault || timeout)  state_nxt = ST_RECOVER;
                    else if (qualified)    state_nxt = ST_LOCKED;
                    else if (fld_lock_i)   state_nxt = ST_CONFIRM;
                    else                   state_nxt = ST_ACQUIRE;
                end
                ST_LOCKED: begin
                    if (fault)     state_nxt = ST_RECOVER;
                    else if (lost) state_nxt = ST_ACQUIRE;
                end
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Requests are forwarded only when the sample was taken in a tracking
    // state and the controller stays in one; the RECOVER->ACQUIRE edge
    // therefore still drives the pump idle.
    assign pass_cp = is_tracking(state) && is_tracking(state_nxt);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_IDLE;
            acq_tmr     <= '0;
            rec_cnt     <= '0;
            cp_up_o     <= 1'b0;
            cp_down_o   <= 1'b0;
            vctrl_rst_o <= 1'b0;
            locked_o    <= 1'b0;
            acq_fail_o  <= 1'b0;
            see_cnt_o   <= '0;
        end else begin
            state       <= state_nxt;
            // Timer spans ACQUIRE<->CONFIRM moves; cleared on any other state.
            acq_tmr     <= (in_acq && (state_nxt == ST_ACQUIRE || state_nxt == ST_CONFIRM))
                           ? acq_tmr + 1'b1 : '0;
            rec_cnt     <= (state == ST_RECOVER && state_nxt == ST_RECOVER)
                           ? rec_cnt + 1'b1 : '0;
            cp_up_o     <= pass_cp & fld_up_i & ~fld_down_i;
            cp_down_o   <= pass_cp & fld_down_i & ~fld_up_i;
            vctrl_rst_o <= (state_nxt == ST_RECOVER);
            locked_o    <= (state_nxt == ST_LOCKED);
            if (en_i && !fault && timeout) begin
                acq_fail_o <= 1'b1;
            end
            if (fault && (see_cnt_o != '1)) begin
                see_cnt_o <= see_cnt_o + 1'b1;
            end
        end
    end

endmodule
